// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: framed UART packets to memory byte reads/writes.
// Optional reply checksums are enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2147700
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] read_ptr,
  output logic        rx_clear,
  input  logic        read_valid,
  input  logic [7:0]  uart_DO,
  output logic [15:0] send_ptr,
  output logic [7:0]  tx_DI,
  output logic        tx_clear,
  input  logic        send_done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_P = 8'h50;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [3:0] {
    IDLE, HDR, WDATA, WMEM, RMEM,
    RCAP, REPLY, DRAIN, RECYCLE
  } state_t;

  state_t state, state_n;

  logic [15:0] rd_idx, base;
  logic [8:0]  len, cnt;
  logic [7:0]  op, status, wdata, q_byte;
  logic [1:0]  hdr_cnt;
  logic [31:0] tmo;
  logic        got, tx_adv, settle;
  logic        fetch, timed, cap;
  logic        tmo_hit, q_en, last;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  xsum;
  logic        rep_cnt;
`endif

  assign fetch   = state inside {IDLE, HDR, WDATA};
  assign timed   = state inside {HDR, WDATA};
  assign cap     = fetch & got;
  assign tmo_hit = timed & ~cap &
                   (tmo >= TIMEOUT_CYCLES - 1);
  assign last    = (cnt + 9'd1) == len;

  assign read_ptr  = rd_idx;
  assign mem_addr  = base + {7'd0, cnt};
  assign mem_wdata = wdata;
  assign mem_we    = state == WMEM;
  assign mem_re    = state == RMEM;
  assign busy      = state != IDLE;
  assign rx_clear  = state == RECYCLE;
  assign tx_clear  = state == RECYCLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    q_en    = 1'b0;
    q_byte  = status;
    cmd_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (cap) begin
          unique case (1'b1)
            (uart_DO == OP_W) || (uart_DO == OP_R):
              state_n = HDR;
            uart_DO == OP_P:
              state_n = REPLY;
            default: begin
              state_n = REPLY;
              cmd_err = 1'b1;
            end
          endcase
        end
      end
      HDR: begin
        if (tmo_hit) begin
          cmd_err = 1'b1;
          state_n = RECYCLE;
        end else if (cap && hdr_cnt == 2'd2) begin
          state_n = (op == OP_W) ? WDATA : RMEM;
        end
      end
      WDATA: begin
        if (tmo_hit) begin
          cmd_err = 1'b1;
          state_n = RECYCLE;
        end else if (cap) begin
          state_n = WMEM;
        end
      end
      WMEM: state_n = last ? REPLY : WDATA;
      RMEM: state_n = RCAP;
      RCAP: begin
        q_en    = 1'b1;
        q_byte  = mem_rdata;
        state_n = last ? REPLY : RMEM;
      end
      REPLY: begin
        q_en    = 1'b1;
        state_n = DRAIN;
`ifdef UART_CMD_CHECKSUM_EN
        // W sends K then sum; R sends sum then K
        if (op == OP_W || op == OP_R) begin
          q_byte = ((op == OP_W) ^ rep_cnt) ? CH_K : xsum;
          if (!rep_cnt) state_n = REPLY;
        end
`endif
      end
      DRAIN: begin
        if (settle && send_done) state_n = RECYCLE;
      end
      RECYCLE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= '0;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
      op       <= '0;
      status   <= '0;
      wdata    <= '0;
      hdr_cnt  <= '0;
      tmo      <= '0;
      got      <= 1'b0;
      tx_adv   <= 1'b0;
      settle   <= 1'b0;
      send_ptr <= '0;
      tx_DI    <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      xsum     <= '0;
      rep_cnt  <= 1'b0;
`endif
    end else begin
      got <= fetch & ~got & read_valid & ~tmo_hit;
      tmo <= (timed & ~cap) ? tmo + 32'd1 : 32'd0;
      if (cap) rd_idx <= rd_idx + 16'd1;
      if (cap && state == IDLE) begin
        op      <= uart_DO;
        status  <= (uart_DO inside {OP_W, OP_R, OP_P})
                   ? CH_K : CH_E;
        hdr_cnt <= '0;
`ifdef UART_CMD_CHECKSUM_EN
        xsum    <= '0;
        rep_cnt <= 1'b0;
`endif
      end
      if (cap && state == HDR) begin
        hdr_cnt <= hdr_cnt + 2'd1;
        case (hdr_cnt)
          2'd0:    base[15:8] <= uart_DO;
          2'd1:    base[7:0]  <= uart_DO;
          default: begin
            // LEN of zero encodes 256
            len <= {uart_DO == 8'd0, uart_DO};
            cnt <= '0;
          end
        endcase
      end
      if (cap && state == WDATA) wdata <= uart_DO;
      if (state == WMEM || state == RCAP) cnt <= cnt + 9'd1;
`ifdef UART_CMD_CHECKSUM_EN
      if (state == WMEM) xsum <= xsum ^ wdata;
      if (state == RCAP) xsum <= xsum ^ mem_rdata;
      if (state == REPLY) rep_cnt <= ~rep_cnt;
`endif
      if (q_en) tx_DI <= q_byte;
      tx_adv <= q_en;
      if (tx_adv) send_ptr <= send_ptr + 16'd1;
      // one settle cycle so a pre-increment send_done is ignored
      settle <= (state == DRAIN) & ~tx_adv;
      if (state_n == RECYCLE) begin
        rd_idx   <= '0;
        send_ptr <= '0;
        tx_adv   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: UART/memory models with a scoreboard on
// sent TX bytes and memory write strobes.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] read_ptr;
  logic        rx_clear;
  logic        read_valid;
  logic [7:0]  uart_DO;
  logic [15:0] send_ptr;
  logic [7:0]  tx_DI;
  logic        tx_clear;
  logic        send_done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        cmd_err;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_ptr(read_ptr), .rx_clear(rx_clear),
    .read_valid(read_valid), .uart_DO(uart_DO),
    .send_ptr(send_ptr), .tx_DI(tx_DI),
    .tx_clear(tx_clear), .send_done(send_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy),
    .cmd_err(cmd_err)
  );

  int n_tests = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int txclr_cnt = 0;
  int err_cnt = 0;
  int tx_cnt = 0;
  int wr_cnt = 0;

  logic [7:0]  exp_tx [$];
  logic [23:0] exp_wr [$];
  logic [7:0]  pkt [$];

  task automatic chk(input string nm, input logic [79:0] got,
                     input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // RX buffer model
  logic [7:0]  rxbuf [0:511];
  logic [15:0] rx_len;
  logic        push;
  logic [7:0]  push_b;

  assign read_valid = read_ptr < rx_len;

  always @(posedge clk) begin
    if (push) rxbuf[rx_len[8:0]] <= push_b;
    uart_DO <= rxbuf[read_ptr[8:0]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_len <= '0;
    else if (rx_clear) rx_len <= '0;
    else if (push) rx_len <= rx_len + 16'd1;
  end

  // TX buffer model: one byte leaves every 3 cycles, send_done lags
  logic [7:0]  txbuf [0:511];
  logic [15:0] tx_sent;
  logic [1:0]  tx_wait;
  logic        tx_fire;
  logic [7:0]  tx_byte;

  always @(posedge clk) txbuf[send_ptr[8:0]] <= tx_DI;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sent   <= '0;
      tx_wait   <= '0;
      tx_fire   <= 1'b0;
      tx_byte   <= '0;
      send_done <= 1'b0;
    end else begin
      tx_fire   <= 1'b0;
      send_done <= tx_sent == send_ptr;
      if (tx_clear) begin
        tx_sent <= '0;
        tx_wait <= '0;
      end else if (tx_sent < send_ptr) begin
        if (tx_wait == 2'd2) begin
          tx_fire <= 1'b1;
          tx_byte <= txbuf[tx_sent[8:0]];
          tx_sent <= tx_sent + 16'd1;
          tx_wait <= '0;
        end else begin
          tx_wait <= tx_wait + 2'd1;
        end
      end
    end
  end

  // memory read model
  always @(posedge clk) begin
    if (mem_re)
      mem_rdata <= (mem_addr == 16'hFFFF) ? 8'h11 :
                   (mem_addr == 16'h0000) ? 8'h22 :
                   mem_addr[7:0] ^ 8'h5A;
  end

  // monitor / scoreboard
  logic [23:0] e;
  always @(negedge clk) begin
    if (rx_clear) clr_cnt++;
    if (tx_clear) txclr_cnt++;
    if (cmd_err) err_cnt++;
    if (tx_fire) begin
      tx_cnt++;
      if (exp_tx.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_extra: got %0h required none", tx_byte);
      end else begin
        chk("tx_byte", tx_byte, exp_tx.pop_front());
      end
    end
    if (mem_we) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_extra: got %0h=%0h required none",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", mem_addr, e[23:8]);
        chk("wr_data", mem_wdata, e[7:0]);
      end
    end
  end

  task automatic send_pkt();
    foreach (pkt[i]) begin
      @(negedge clk);
      push   = 1'b1;
      push_b = pkt[i];
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_recycle(input string nm, input int budget);
    int c0;
    int n;
    c0 = clr_cnt;
    n = 0;
    while (clr_cnt == c0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_recycle"}, 80'(clr_cnt != c0), 80'd1);
    repeat (2) @(negedge clk);
    chk({nm, "_busy"}, 80'(busy), 80'd0);
  endtask

  function automatic logic [79:0] outs();
    return 80'({read_ptr, rx_clear, send_ptr, tx_DI, tx_clear,
                mem_addr, mem_wdata, mem_we, mem_re, busy,
                cmd_err});
  endfunction

  initial begin
    int e0;
    int t0;
    int w0;
    int n;
    logic [7:0] x;
    logic [7:0] d;
    rst_n  = 1'b0;
    push   = 1'b0;
    push_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 80'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ping
    e0 = err_cnt;
    exp_tx.push_back(8'h4B);
    pkt = '{8'h50};
    send_pkt();
    wait_recycle("ping", 200);
    chk("ping_err", 80'(err_cnt - e0), 80'd0);

    // write two bytes
    exp_wr.push_back({16'h1234, 8'hAA});
    exp_wr.push_back({16'h1235, 8'h55});
    exp_tx.push_back(8'h4B);
`ifdef UART_CMD_CHECKSUM_EN
    exp_tx.push_back(8'hFF);
`endif
    w0 = wr_cnt;
    pkt = '{8'h57, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55};
    send_pkt();
    wait_recycle("write", 300);
    chk("write_count", 80'(wr_cnt - w0), 80'd2);

    // read with address wrap
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
`ifdef UART_CMD_CHECKSUM_EN
    exp_tx.push_back(8'h33);
`endif
    exp_tx.push_back(8'h4B);
    t0 = tx_cnt;
    pkt = '{8'h52, 8'hFF, 8'hFF, 8'h02};
    send_pkt();
    wait_recycle("read", 300);
`ifdef UART_CMD_CHECKSUM_EN
    chk("read_txcount", 80'(tx_cnt - t0), 80'd4);
`else
    chk("read_txcount", 80'(tx_cnt - t0), 80'd3);
`endif

    // LEN=0 write of 256 bytes wrapping past 0xFFFF
    w0 = wr_cnt;
    x = 8'h00;
    pkt = '{8'h57, 8'hFF, 8'h80, 8'h00};
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) ^ 8'h3C;
      x = x ^ d;
      pkt.push_back(d);
      exp_wr.push_back({16'(16'hFF80 + 16'(i)), d});
    end
    exp_tx.push_back(8'h4B);
`ifdef UART_CMD_CHECKSUM_EN
    exp_tx.push_back(x);
`endif
    send_pkt();
    wait_recycle("len0", 5000);
    chk("len0_count", 80'(wr_cnt - w0), 80'd256);

    // unknown opcode
    e0 = err_cnt;
    exp_tx.push_back(8'h45);
    pkt = '{8'h00};
    send_pkt();
    wait_recycle("unknown", 200);
    chk("unknown_err", 80'(err_cnt - e0), 80'd1);

    // header stall
    e0 = err_cnt;
    t0 = tx_cnt;
    pkt = '{8'h52, 8'h12};
    send_pkt();
    wait_recycle("timeout", 400);
    chk("timeout_err", 80'(err_cnt - e0), 80'd1);
    chk("timeout_tx", 80'(tx_cnt - t0), 80'd0);

    // reset while waiting for data byte 3
    w0 = wr_cnt;
    exp_wr.push_back({16'h0010, 8'hA1});
    exp_wr.push_back({16'h0011, 8'hA2});
    pkt = '{8'h57, 8'h00, 8'h10, 8'h04, 8'hA1, 8'hA2};
    send_pkt();
    n = 0;
    while (wr_cnt < w0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_writes", 80'(wr_cnt - w0), 80'd2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_outputs", outs(), 80'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold", outs(), 80'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_tx.push_back(8'h4B);
    pkt = '{8'h50};
    send_pkt();
    wait_recycle("rst_ping", 200);

    chk("tx_left", 80'(exp_tx.size()), 80'd0);
    chk("wr_left", 80'(exp_wr.size()), 80'd0);
    chk("clr_pair", 80'(txclr_cnt), 80'(clr_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
